s3_power_ctrl: RTL and testbench
================================

Name: s3_power_ctrl

Overview:
- S3 sequencer directly upstream of the ALU-context RAM.
- Drives the RAM's `s3_state` and `write_enable` pins. Gates the ALU via `alu_enable`.
- Sequences save-to-RAM on sleep entry, a timed sleep, wake settling, and restore-from-RAM on exit. Flags the cycle when restored context is valid on the RAM outputs.

Parameters:
- MIN_SLEEP, default 8: cycles spent in SLEEP before a wake may be honoured. Must be ≥ 1.
- WAKE_DELAY, default 4: cycles spent in WAKE for supply/clock settling before restore. Must be ≥ 1.
- AUTO_WAKE_CYCLES, default 64: SLEEP timeout. Used only with S3_AUTO_WAKE_EN. Must be > MIN_SLEEP.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sleep_req  in  1  level request to enter S3
- alu_busy  in  1  ALU mid-operation; blocks sleep entry
- wake_event  in  1  wake source; pulse or level
- s3_state  out  1  to RAM `s3_state`; 1 = save direction / asleep
- write_enable  out  1  to RAM `write_enable`; one-cycle strobe
- alu_enable  out  1  ALU clock-enable; 0 while powered down
- sleep_ack  out  1  high while in SLEEP
- restore_valid  out  1  one-cycle pulse: RAM outputs hold restored context
- power_state  out  3  current FSM state encoding, for debug/status

Behaviour:
- All outputs are registered and update on the same edge the FSM enters a state (Moore).
- Reset is asynchronous and may occur mid-sequence. Reset forces:
  - state = ACTIVE, counters = 0, wake_pending = 0
  - s3_state = 0, write_enable = 0, alu_enable = 1, sleep_ack = 0, restore_valid = 0, power_state = 0
- States and per-state outputs (s3_state / write_enable / alu_enable):
  - ACTIVE (0): 0/0/1. Goes to SAVE when `sleep_req=1 & alu_busy=0`. While `alu_busy=1`, stays ACTIVE indefinitely; the request is not latched.
  - SAVE (1): 1/1/1, exactly 1 cycle. The RAM captures the ALU context on the edge leaving SAVE. Then goes to SLEEP.
  - SLEEP (2): 1/0/0, `sleep_ack=1`. Counter runs from 0.
    - Leave to WAKE when `counter ≥ MIN_SLEEP-1` and (`wake_pending` or `wake_event`).
    - A wake before MIN_SLEEP is held in `wake_pending`, not dropped.
  - WAKE (3): 0/0/0 for WAKE_DELAY cycles, then RESTORE.
  - RESTORE (4): 0/1/0, exactly 1 cycle. The RAM loads its outputs on the edge leaving RESTORE. Then goes to DONE.
  - DONE (5): 0/0/1, `restore_valid=1` for exactly 1 cycle. Then ACTIVE.
- `wake_pending`:
  - Set by `wake_event` in SAVE or SLEEP.
  - Cleared on SLEEP→WAKE exit and on reset.
  - `wake_event` in any other state is ignored.
- `sleep_req` outside ACTIVE is ignored. If `sleep_req` is still high on return to ACTIVE, a new cycle starts one cycle later (ACTIVE is occupied for at least 1 cycle).
- Simultaneous `sleep_req` and `wake_event` in ACTIVE: enter SAVE; the wake is not latched.
- Latency:
  - `sleep_req` sampled to `write_enable` high: 1 cycle.
  - Qualified wake to `restore_valid`: WAKE_DELAY + 2 cycles.
- Counter width is `$clog2` of the largest count in use, plus 1. It saturates; it never wraps.
- `write_enable` is never high in two consecutive cycles.
- `s3_state` only changes while `write_enable=0`, so a RAM store and a RAM retrieve can never merge.

Optional Feature:
- S3_AUTO_WAKE_EN defined:
  - SLEEP also exits to WAKE when the counter reaches AUTO_WAKE_CYCLES-1, with no wake_event required.
  - An external wake still exits earlier, subject to MIN_SLEEP.
- Undefined: SLEEP is held indefinitely until a wake. The port list is identical in both builds.

Decomposition:
- Package `s3_pm_pkg`:
  - state typedef/localparams ACTIVE=0, SAVE=1, SLEEP=2, WAKE=3, RESTORE=4, DONE=5
  - STATE_W = 3
  - counter-width function
- Sub-module `s3_delay_counter`: loadable saturating counter with a terminal-count flag. Shared by the SLEEP and WAKE timing.

Test Plan:
- Reset then idle 10 cycles → `s3_state=0`, `write_enable=0`, `alu_enable=1`, `power_state=0`.
- Full cycle (MIN_SLEEP=8, WAKE_DELAY=4): `sleep_req` at cycle 5 → `write_enable`/`s3_state` high in cycle 6; SLEEP from cycle 7. `wake_event` at cycle 20 → WAKE cycles 21-24, RESTORE 25, `restore_valid` 26. With the RAM attached, result/operands/opcode saved at cycle 6 appear on the RAM outputs in cycle 26.
- Early wake: `wake_event` pulse at SLEEP cycle 2 → `wake_pending` set; WAKE entered exactly after 8 SLEEP cycles.
- `alu_busy` high for 5 cycles with `sleep_req` held → SAVE entered only on the cycle after `alu_busy` falls. `sleep_req` toggled during SLEEP → no effect.
- Reset asserted asynchronously mid-WAKE and mid-SAVE → outputs return to reset values immediately; a subsequent cycle completes normally.
- S3_AUTO_WAKE_EN, AUTO_WAKE_CYCLES=64, no `wake_event` → exit SLEEP after exactly 64 cycles. Without the macro → still in SLEEP at cycle 200.

Source files
------------

// File: rtl/s3_power_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// s3_pm_pkg
// Shared definitions for the S3 power sequencer:
//   - pm_state_t   : FSM state encoding (also exported on power_state)
//   - pm_out_t     : bundle of the registered Moore outputs
//   - state_outputs: per-state output decode
//   - cnt_width    : width of the shared delay counter for a given max count
//   - max_int      : small helper for sizing
// ----------------------------------------------------------------------------
package s3_pm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ACTIVE  = 3'd0,
        SAVE    = 3'd1,
        SLEEP   = 3'd2,
        WAKE    = 3'd3,
        RESTORE = 3'd4,
        DONE    = 3'd5
    } pm_state_t;

    typedef struct packed {
        logic s3;       // RAM s3_state
        logic we;       // RAM write_enable
        logic alu_en;   // ALU clock enable
        logic ack;      // sleep_ack
        logic rv;       // restore_valid
    } pm_out_t;

    // Moore output table; the FSM loads this on the edge it enters a state.
    function automatic pm_out_t state_outputs(input pm_state_t s);
        pm_out_t o;
        o = '{s3: 1'b0, we: 1'b0, alu_en: 1'b1, ack: 1'b0, rv: 1'b0};
        case (s)
            ACTIVE:  o = '{s3: 1'b0, we: 1'b0, alu_en: 1'b1, ack: 1'b0, rv: 1'b0};
            SAVE:    o = '{s3: 1'b1, we: 1'b1, alu_en: 1'b1, ack: 1'b0, rv: 1'b0};
            SLEEP:   o = '{s3: 1'b1, we: 1'b0, alu_en: 1'b0, ack: 1'b1, rv: 1'b0};
            WAKE:    o = '{s3: 1'b0, we: 1'b0, alu_en: 1'b0, ack: 1'b0, rv: 1'b0};
            RESTORE: o = '{s3: 1'b0, we: 1'b1, alu_en: 1'b0, ack: 1'b0, rv: 1'b0};
            DONE:    o = '{s3: 1'b0, we: 1'b0, alu_en: 1'b1, ack: 1'b0, rv: 1'b1};
            default: o = '{s3: 1'b0, we: 1'b0, alu_en: 1'b1, ack: 1'b0, rv: 1'b0};
        endcase
        return o;
    endfunction

    // One spare bit above $clog2 so the counter can sit at/after max-1 and
    // still compare correctly while saturated.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/s3_power_ctrl_delay_counter.sv
// ----------------------------------------------------------------------------
// s3_delay_counter
// Loadable up-counter that saturates at all-ones (never wraps), with a
// terminal-count flag. One instance times both SLEEP and WAKE.
// Ports:
//   clk, reset   : clock, async active-high reset (count -> 0)
//   i_load       : load i_load_val this cycle (takes priority over i_en)
//   i_load_val   : value to load
//   i_en         : count enable
//   i_term       : terminal value
//   o_count      : current count
//   o_tc         : o_count >= i_term
// ----------------------------------------------------------------------------
module s3_delay_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count >= i_term);

endmodule

// File: rtl/s3_power_ctrl.sv
// ----------------------------------------------------------------------------
// s3_power_ctrl
// S3 sleep sequencer in front of the ALU-context RAM: saves context on sleep
// entry, holds a timed sleep, waits for supply/clock settling on wake, then
// restores context and flags the cycle the restored data is valid.
//
// Optional feature macro: S3_AUTO_WAKE_EN
//   defined   : SLEEP also exits on its own after AUTO_WAKE_CYCLES cycles.
//   undefined : SLEEP is held until a wake (wake_event / latched wake).
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   sleep_req     in   level request to enter S3 (honoured only in ACTIVE)
//   alu_busy      in   blocks sleep entry while high
//   wake_event    in   wake source, pulse or level
//   s3_state      out  RAM s3_state (1 = save direction / asleep)
//   write_enable  out  RAM write strobe (SAVE and RESTORE, one cycle each)
//   alu_enable    out  ALU clock enable
//   sleep_ack     out  high while in SLEEP
//   restore_valid out  one-cycle pulse, RAM outputs hold restored context
//   power_state   out  current state encoding
// ----------------------------------------------------------------------------
module s3_power_ctrl
    import s3_pm_pkg::*;
#(
    parameter int MIN_SLEEP        = 8,
    parameter int WAKE_DELAY       = 4,
    parameter int AUTO_WAKE_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sleep_req,
    input  logic         alu_busy,
    input  logic         wake_event,
    output logic         s3_state,
    output logic         write_enable,
    output logic         alu_enable,
    output logic         sleep_ack,
    output logic         restore_valid,
    output logic [2:0]   power_state
);

    // Counter is sized to cover the auto-wake timeout as well, so both builds
    // share the same datapath width.
    localparam int MAX_CNT = max_int(max_int(MIN_SLEEP, WAKE_DELAY), AUTO_WAKE_CYCLES);
    localparam int CW      = cnt_width(MAX_CNT);

    localparam logic [CW-1:0] SLEEP_TERM = CW'(MIN_SLEEP - 1);
    localparam logic [CW-1:0] WAKE_TERM  = CW'(WAKE_DELAY - 1);
`ifdef S3_AUTO_WAKE_EN
    localparam logic [CW-1:0] AUTO_TERM  = CW'(AUTO_WAKE_CYCLES - 1);
`endif

    pm_state_t     r_state;
    pm_out_t       r_out;
    logic          r_wake_pending;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_term;
    logic          w_tc;
    logic          w_wake;
    logic          w_auto;
    logic          w_sleep_exit;
    logic          w_wake_done;
    logic          w_cnt_load;

    assign w_term = (r_state == WAKE) ? WAKE_TERM : SLEEP_TERM;
    assign w_wake = r_wake_pending | wake_event;

`ifdef S3_AUTO_WAKE_EN
    assign w_auto = (w_count >= AUTO_TERM);
`else
    assign w_auto = 1'b0;
`endif

    assign w_sleep_exit = (r_state == SLEEP) && ((w_tc && w_wake) || w_auto);
    assign w_wake_done  = (r_state == WAKE) && w_tc;

    // Counter is held at zero outside the timed states, and re-zeroed on the
    // SLEEP->WAKE edge, so each timed state sees count 0 on its first cycle.
    assign w_cnt_load = !((r_state == SLEEP) || (r_state == WAKE)) || w_sleep_exit;

    s3_delay_counter #(
        .W (CW)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val ({CW{1'b0}}),
        .i_en       (1'b1),
        .i_term     (w_term),
        .o_count    (w_count),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ACTIVE;
            r_out          <= state_outputs(ACTIVE);
            r_wake_pending <= 1'b0;
        end else begin
            case (r_state)
                ACTIVE: begin
                    // Not latched: a blocked request simply waits here.
                    if (sleep_req && !alu_busy) begin
                        r_state <= SAVE;
                        r_out   <= state_outputs(SAVE);
                    end
                end
                SAVE: begin
                    r_state <= SLEEP;
                    r_out   <= state_outputs(SLEEP);
                    if (wake_event) r_wake_pending <= 1'b1;
                end
                SLEEP: begin
                    if (w_sleep_exit) begin
                        r_state        <= WAKE;
                        r_out          <= state_outputs(WAKE);
                        r_wake_pending <= 1'b0;
                    end else if (wake_event) begin
                        // Early wake is remembered until MIN_SLEEP has elapsed.
                        r_wake_pending <= 1'b1;
                    end
                end
                WAKE: begin
                    if (w_wake_done) begin
                        r_state <= RESTORE;
                        r_out   <= state_outputs(RESTORE);
                    end
                end
                RESTORE: begin
                    r_state <= DONE;
                    r_out   <= state_outputs(DONE);
                end
                DONE: begin
                    r_state <= ACTIVE;
                    r_out   <= state_outputs(ACTIVE);
                end
                default: begin
                    r_state <= ACTIVE;
                    r_out   <= state_outputs(ACTIVE);
                end
            endcase
        end
    end

    assign s3_state      = r_out.s3;
    assign write_enable  = r_out.we;
    assign alu_enable    = r_out.alu_en;
    assign sleep_ack     = r_out.ack;
    assign restore_valid = r_out.rv;
    assign power_state   = r_state;

endmodule

// File: tb/tb_s3_power_ctrl.sv
// ----------------------------------------------------------------------------
// tb_s3_power_ctrl
// Directed stimulus pushes the expected state transitions (state + cycle) into
// a scoreboard queue; a monitor pops one entry each time power_state changes
// and checks state, cycle and the Moore outputs for that state.
// ----------------------------------------------------------------------------
module tb_s3_power_ctrl;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       sleep_req  = 1'b0;
    logic       alu_busy   = 1'b0;
    logic       wake_event = 1'b0;
    logic       s3_state;
    logic       write_enable;
    logic       alu_enable;
    logic       sleep_ack;
    logic       restore_valid;
    logic [2:0] power_state;

    s3_power_ctrl #(
        .MIN_SLEEP        (8),
        .WAKE_DELAY       (4),
        .AUTO_WAKE_CYCLES (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sleep_req     (sleep_req),
        .alu_busy      (alu_busy),
        .wake_event    (wake_event),
        .s3_state      (s3_state),
        .write_enable  (write_enable),
        .alu_enable    (alu_enable),
        .sleep_ack     (sleep_ack),
        .restore_valid (restore_valid),
        .power_state   (power_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [2:0] S_ACT = 3'd0, S_SAV = 3'd1, S_SLP = 3'd2,
                           S_WAK = 3'd3, S_RES = 3'd4, S_DON = 3'd5;

    typedef struct {
        int         c;      // expected cycle of entry, -1 = don't care
        logic [2:0] ps;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // {s3_state, write_enable, alu_enable, sleep_ack, restore_valid}
    function automatic logic [4:0] model_outs(input logic [2:0] ps);
        case (ps)
            S_ACT:   return 5'b00100;
            S_SAV:   return 5'b11100;
            S_SLP:   return 5'b10010;
            S_WAK:   return 5'b00000;
            S_RES:   return 5'b01000;
            S_DON:   return 5'b00101;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic expect_st(input int c, input logic [2:0] ps, input string tag);
        exp_t e;
        e.c = c; e.ps = ps; e.tag = tag;
        sb.push_back(e);
    endtask

    // Full sleep/wake walk from a given start; wake sampled on edge wc+1.
    task automatic expect_wake_tail(input int wc, input string tag);
        expect_st(wc + 1, S_WAK, {tag, "_wake"});
        expect_st(wc + 5, S_RES, {tag, "_restore"});
        expect_st(wc + 6, S_DON, {tag, "_done"});
        expect_st(wc + 7, S_ACT, {tag, "_active"});
    endtask

    // Advance to the negedge at which cyc == c.
    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // ------------------------------------------------------------------ monitor
    logic [2:0] last_ps = 3'd7;
    always @(negedge clk or posedge reset) begin
        exp_t       e;
        logic [4:0] got;
        #1;
        if (!$isunknown(power_state) && power_state !== last_ps) begin
            got = {s3_state, write_enable, alu_enable, sleep_ack, restore_valid};
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_change: got state %0d at cycle %0d, expected no change",
                         power_state, cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (power_state !== e.ps) begin
                    errors++;
                    $display("FAIL %s state: got %0d expected %0d", e.tag, power_state, e.ps);
                end
                if (e.c >= 0) begin
                    checks++;
                    if (cyc != e.c) begin
                        errors++;
                        $display("FAIL %s cycle: got %0d expected %0d", e.tag, cyc, e.c);
                    end
                end
                checks++;
                if (got !== model_outs(e.ps)) begin
                    errors++;
                    $display("FAIL %s outputs: got %b expected %b", e.tag, got, model_outs(e.ps));
                end
            end
            last_ps = power_state;
        end
    end

    // write_enable must never be high two cycles running
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        #1;
        if (write_enable === 1'b1) begin
            checks++;
            if (prev_we === 1'b1) begin
                errors++;
                $display("FAIL we_back_to_back: got 1 on consecutive cycles at %0d expected 0", cyc);
            end
        end
        prev_we = write_enable;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------------- stimulus
    initial begin
        int c0;
        expect_st(-1, S_ACT, "reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);          // idle: any change is flagged

        // Full cycle, wake well after MIN_SLEEP
        c0 = cyc;
        sleep_req = 1'b1;
        expect_st(c0 + 1, S_SAV, "full_save");
        expect_st(c0 + 2, S_SLP, "full_sleep");
        wait_to(c0 + 1);  sleep_req = 1'b0;
        wait_to(c0 + 15); wake_event = 1'b1;
        expect_wake_tail(c0 + 15, "full");
        wait_to(c0 + 16); wake_event = 1'b0;
        wait_to(c0 + 25);

        // Early wake pulse at SLEEP count 2 is held until 8 SLEEP cycles done
        c0 = cyc;
        sleep_req = 1'b1;
        expect_st(c0 + 1, S_SAV, "early_save");
        expect_st(c0 + 2, S_SLP, "early_sleep");
        wait_to(c0 + 1);  sleep_req = 1'b0;
        wait_to(c0 + 4);  wake_event = 1'b1;
        expect_wake_tail(c0 + 9, "early");
        wait_to(c0 + 5);  wake_event = 1'b0;
        wait_to(c0 + 20);

        // alu_busy blocks entry; sleep_req toggling in SLEEP is ignored;
        // sleep_req held through DONE restarts one cycle after ACTIVE
        c0 = cyc;
        sleep_req = 1'b1; alu_busy = 1'b1;
        wait_to(c0 + 5);  alu_busy = 1'b0;
        expect_st(c0 + 6, S_SAV, "busy_save");
        expect_st(c0 + 7, S_SLP, "busy_sleep");
        wait_to(c0 + 7);  sleep_req = 1'b0;
        wait_to(c0 + 8);  sleep_req = 1'b1;
        wait_to(c0 + 9);  sleep_req = 1'b0;
        wait_to(c0 + 20); wake_event = 1'b1;
        expect_wake_tail(c0 + 20, "busy");
        wait_to(c0 + 21); wake_event = 1'b0;
        wait_to(c0 + 24); sleep_req = 1'b1;
        expect_st(c0 + 28, S_SAV, "again_save");
        expect_st(c0 + 29, S_SLP, "again_sleep");
        wait_to(c0 + 28); sleep_req = 1'b0;
        wait_to(c0 + 40); wake_event = 1'b1;
        expect_wake_tail(c0 + 40, "again");
        wait_to(c0 + 41); wake_event = 1'b0;
        wait_to(c0 + 50);

        // Simultaneous sleep_req and wake_event in ACTIVE: wake not latched
        c0 = cyc;
        sleep_req = 1'b1; wake_event = 1'b1;
        expect_st(c0 + 1, S_SAV, "simul_save");
        expect_st(c0 + 2, S_SLP, "simul_sleep");
        wait_to(c0 + 1);  sleep_req = 1'b0; wake_event = 1'b0;
        wait_to(c0 + 30); wake_event = 1'b1;
        expect_wake_tail(c0 + 30, "simul");
        wait_to(c0 + 31); wake_event = 1'b0;
        wait_to(c0 + 40);

        // Async reset mid-WAKE
        c0 = cyc;
        sleep_req = 1'b1;
        expect_st(c0 + 1, S_SAV, "rstw_save");
        expect_st(c0 + 2, S_SLP, "rstw_sleep");
        expect_st(c0 + 11, S_WAK, "rstw_wake");
        wait_to(c0 + 1);  sleep_req = 1'b0;
        wait_to(c0 + 10); wake_event = 1'b1;
        wait_to(c0 + 11); wake_event = 1'b0;
        wait_to(c0 + 12);
        @(posedge clk); #2;
        expect_st(cyc, S_ACT, "rstw_reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Async reset mid-SAVE
        c0 = cyc;
        sleep_req = 1'b1;
        expect_st(c0 + 1, S_SAV, "rsts_save");
        wait_to(c0 + 1);  sleep_req = 1'b0;
        #3;
        expect_st(cyc, S_ACT, "rsts_reset");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Normal cycle after the resets
        c0 = cyc;
        sleep_req = 1'b1;
        expect_st(c0 + 1, S_SAV, "post_save");
        expect_st(c0 + 2, S_SLP, "post_sleep");
        wait_to(c0 + 1);  sleep_req = 1'b0;
        wait_to(c0 + 12); wake_event = 1'b1;
        expect_wake_tail(c0 + 12, "post");
        wait_to(c0 + 13); wake_event = 1'b0;
        wait_to(c0 + 22);

        // No wake: auto exit after 64 SLEEP cycles, or held indefinitely
        c0 = cyc;
        sleep_req = 1'b1;
        expect_st(c0 + 1, S_SAV, "auto_save");
        expect_st(c0 + 2, S_SLP, "auto_sleep");
        wait_to(c0 + 1);  sleep_req = 1'b0;
`ifdef S3_AUTO_WAKE_EN
        expect_wake_tail(c0 + 65, "auto");
        wait_to(c0 + 80);
`else
        wait_to(c0 + 200);
        checks++;
        if (power_state !== S_SLP) begin
            errors++;
            $display("FAIL hold_sleep_200: got %0d expected %0d", power_state, S_SLP);
        end
        wake_event = 1'b1;
        expect_wake_tail(c0 + 200, "hold");
        wait_to(c0 + 201); wake_event = 1'b0;
        wait_to(c0 + 210);
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
